// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register that sits directly in front of the 16-bit ALU.
//   It captures the decoded operands and control fields, forwards results
//   from EX/MEM and MEM/WB into the ALU operands, and flags load-use hazards
//   back to the fetch/decode stages.
//
//   Ports
//     clk, rst                      rising-edge clock, async active-high reset
//     stall, flush                  hold this stage / load a bubble
//     in_*                          decoded instruction from the ID stage
//     exm_*, wb_*                   forwarding sources (already valid-qualified)
//     ex_valid                      EX slot holds a real instruction
//     alu_x, alu_y, alu_cin,        ALU operand and control inputs
//     alu_opcod
//     ex_store_data                 forwarded rt value (store data)
//     ex_rd_addr, ex_reg_write,     registered destination and control
//     ex_mem_read
//     load_use_stall                combinational stall request to IF/ID
module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 8,
    parameter int OP_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic              in_use_imm,
    input  logic              in_cin,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_cin,
    output logic [OP_W-1:0]   alu_opcod,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              load_use_stall
);

    logic              valid_q,     valid_d;
    logic [REG_AW-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic              use_imm_q,   use_imm_d;
    logic              cin_q,       cin_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] imm_sext;

    assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    // Forwarding muxes: r0 never forwards, EX/MEM beats MEM/WB.
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_addr_q != '0) begin
            if (exm_reg_write && (exm_rd_addr == rs_addr_q))
                fwd_rs = exm_result;
            else if (wb_reg_write && (wb_rd_addr == rs_addr_q))
                fwd_rs = wb_result;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_addr_q != '0) begin
            if (exm_reg_write && (exm_rd_addr == rt_addr_q))
                fwd_rt = exm_result;
            else if (wb_reg_write && (wb_rd_addr == rt_addr_q))
                fwd_rt = wb_result;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;
    assign ex_rd_addr    = rd_addr_q;
    assign alu_x         = fwd_rs;
    assign alu_y         = use_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_cin       = cin_q;
    assign alu_opcod     = alu_op_q;

    // rt only matters as a hazard source when it actually feeds the ALU.
    assign load_use_stall = in_valid & ex_mem_read & (rd_addr_q != '0) &
                            ((rd_addr_q == in_rs_addr) |
                             ((rd_addr_q == in_rt_addr) & ~in_use_imm));

    always_comb begin
        valid_d     = valid_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        use_imm_d   = use_imm_q;
        cin_d       = cin_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (stall) begin
            // Absorb forwarded values while held: the producer may retire
            // from the bypass network before the hold ends.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else if (load_use_stall) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            valid_d     = in_valid;
            rs_addr_d   = in_rs_addr;
            rt_addr_d   = in_rt_addr;
            rd_addr_d   = in_rd_addr;
            rs_data_d   = in_rs_data;
            rt_data_d   = in_rt_data;
            imm_d       = imm_sext;
            alu_op_d    = in_alu_op;
            use_imm_d   = in_use_imm;
            cin_d       = in_cin;
            reg_write_d = in_reg_write;
            mem_read_d  = in_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            use_imm_q   <= 1'b0;
            cin_q       <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            use_imm_q   <= use_imm_d;
            cin_q       <= cin_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid;
    logic [15:0] in_rs_data, in_rt_data;
    logic [7:0]  in_imm;
    logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [0:0]  in_alu_op;
    logic        in_use_imm, in_cin, in_reg_write, in_mem_read;
    logic        exm_reg_write;
    logic [2:0]  exm_rd_addr;
    logic [15:0] exm_result;
    logic        wb_reg_write;
    logic [2:0]  wb_rd_addr;
    logic [15:0] wb_result;
    logic        ex_valid;
    logic [15:0] alu_x, alu_y, ex_store_data;
    logic        alu_cin;
    logic [0:0]  alu_opcod;
    logic [2:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, load_use_stall;

    int checks   = 0;
    int failures = 0;

    id_ex_operand_stage #(.DATA_W(16), .REG_AW(3), .IMM_W(8), .OP_W(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rd_addr(in_rd_addr), .in_alu_op(in_alu_op), .in_use_imm(in_use_imm),
        .in_cin(in_cin), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
        .exm_result(exm_result), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
        .alu_opcod(alu_opcod), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0;
        in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0; in_alu_op = '0;
        in_use_imm = 1'b0; in_cin = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
        exm_reg_write = 1'b0; exm_rd_addr = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd_addr = '0; wb_result = '0;
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_alu_x",    32'(alu_x),    32'd0);
        check("rst_alu_y",    32'(alu_y),    32'd0);
        check("rst_store",    32'(ex_store_data), 32'd0);
        check("rst_cin",      32'(alu_cin),  32'd0);
        check("rst_opcod",    32'(alu_opcod), 32'd0);
        check("rst_lus",      32'(load_use_stall), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Plain load, no hazards.
        in_valid = 1'b1; in_rs_addr = 3'd1; in_rs_data = 16'h0003;
        in_rt_addr = 3'd2; in_rt_data = 16'h0003; in_rd_addr = 3'd3;
        in_alu_op = 1'b1; in_cin = 1'b1; in_reg_write = 1'b1;
        tick();
        check("ld_alu_x",     32'(alu_x), 32'h0003);
        check("ld_alu_y",     32'(alu_y), 32'h0003);
        check("ld_ex_valid",  32'(ex_valid), 32'd1);
        check("ld_cin",       32'(alu_cin), 32'd1);
        check("ld_opcod",     32'(alu_opcod), 32'd1);
        check("ld_rd",        32'(ex_rd_addr), 32'd3);
        check("ld_reg_write", 32'(ex_reg_write), 32'd1);
        check("ld_mem_read",  32'(ex_mem_read), 32'd0);

        // Forwarding priority.
        in_rs_addr = 3'd4; in_rs_data = 16'h1111;
        in_rt_addr = 3'd5; in_rt_data = 16'h2222; in_cin = 1'b0; in_alu_op = 1'b0;
        tick();
        exm_reg_write = 1'b1; exm_rd_addr = 3'd4; exm_result = 16'h01F4;
        wb_reg_write = 1'b1; wb_rd_addr = 3'd4; wb_result = 16'h0000;
        #1;
        check("fwd_exm_prio", 32'(alu_x), 32'h01F4);
        exm_reg_write = 1'b0;
        #1;
        check("fwd_wb_only", 32'(alu_x), 32'h0000);
        wb_reg_write = 1'b0;
        #1;
        check("fwd_none", 32'(alu_x), 32'h1111);
        wb_reg_write = 1'b1; wb_rd_addr = 3'd5; wb_result = 16'h0ABC;
        #1;
        check("fwd_wb_rt_y",     32'(alu_y), 32'h0ABC);
        check("fwd_wb_rt_store", 32'(ex_store_data), 32'h0ABC);
        wb_reg_write = 1'b0;
        in_rs_addr = 3'd0; in_rs_data = 16'h0000;
        tick();
        exm_reg_write = 1'b1; exm_rd_addr = 3'd0; exm_result = 16'hBEEF;
        #1;
        check("fwd_r0", 32'(alu_x), 32'h0000);
        exm_reg_write = 1'b0; exm_rd_addr = 3'd0; exm_result = '0;

        // Immediate operand.
        in_use_imm = 1'b1; in_imm = 8'hFE; in_rt_addr = 3'd2; in_rt_data = 16'h0007;
        tick();
        check("imm_neg_y",     32'(alu_y), 32'hFFFE);
        check("imm_store",     32'(ex_store_data), 32'h0007);
        wb_reg_write = 1'b1; wb_rd_addr = 3'd2; wb_result = 16'h1234;
        #1;
        check("imm_y_nofwd",   32'(alu_y), 32'hFFFE);
        check("imm_store_fwd", 32'(ex_store_data), 32'h1234);
        wb_reg_write = 1'b0;
        in_imm = 8'h7F;
        tick();
        check("imm_pos_y", 32'(alu_y), 32'h007F);

        // Load-use hazard.
        in_use_imm = 1'b0; in_rd_addr = 3'd2; in_mem_read = 1'b1;
        in_rs_addr = 3'd1; in_rt_addr = 3'd3;
        tick();
        check("lu_ex_mem_read", 32'(ex_mem_read), 32'd1);
        in_mem_read = 1'b0; in_rd_addr = 3'd4;
        in_rs_addr = 3'd2; in_rt_addr = 3'd3;
        #1;
        check("lu_rs_hit", 32'(load_use_stall), 32'd1);
        in_rs_addr = 3'd3; in_rt_addr = 3'd2; in_use_imm = 1'b1;
        #1;
        check("lu_rt_imm_nohit", 32'(load_use_stall), 32'd0);
        in_use_imm = 1'b0;
        #1;
        check("lu_rt_hit", 32'(load_use_stall), 32'd1);
        in_valid = 1'b0;
        #1;
        check("lu_in_invalid", 32'(load_use_stall), 32'd0);
        in_valid = 1'b1;
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_mr",    32'(ex_mem_read), 32'd0);
        check("lu_cleared",      32'(load_use_stall), 32'd0);

        // Stall with writeback arriving during the hold.
        in_rs_addr = 3'd6; in_rs_data = 16'h0011; in_rt_addr = 3'd1; in_rt_data = 16'h0022;
        in_rd_addr = 3'd5; in_reg_write = 1'b1;
        tick();
        check("st_load_x", 32'(alu_x), 32'h0011);
        stall = 1'b1; in_rs_data = 16'h5555; in_rd_addr = 3'd7;
        tick();
        check("st_c1_x",  32'(alu_x), 32'h0011);
        check("st_c1_rd", 32'(ex_rd_addr), 32'd5);
        wb_reg_write = 1'b1; wb_rd_addr = 3'd6; wb_result = 16'h00C8;
        tick();
        wb_reg_write = 1'b0; wb_rd_addr = 3'd0; wb_result = '0;
        #1;
        check("st_after_wb_x", 32'(alu_x), 32'h00C8);
        tick();
        check("st_c3_x",     32'(alu_x), 32'h00C8);
        check("st_c3_valid", 32'(ex_valid), 32'd1);
        flush = 1'b1;
        tick();
        check("flush_over_stall_valid", 32'(ex_valid), 32'd0);
        check("flush_over_stall_rw",    32'(ex_reg_write), 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Asynchronous reset mid-run, during a stall.
        tick();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        check("pre_rst_x",     32'(alu_x), 32'h5555);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_x",     32'(alu_x), 32'd0);
        check("arst_y",     32'(alu_y), 32'd0);
        check("arst_rw",    32'(ex_reg_write), 32'd0);
        tick();
        rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(ex_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
